// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC selection and the IF/ID
// pipeline register feeding decode.
module adder (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y
);
   assign y = a + b;
endmodule

module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_f,
   input  logic        stall_d,
   input  logic        flush_d,
   input  logic        pc_src_e,
   input  logic [31:0] pc_target_e,
   input  logic [31:0] instr_f,
   output logic [31:0] pc_f,
   output logic [31:0] pc_plus4_f,
   output logic        misaligned_f,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [31:0] pc_plus4_d,
   output logic        valid_d
);
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0] pc_next;

   adder u_pc_add (
      .a(pc_f),
      .b(32'd4),
      .y(pc_plus4_f)
   );

   assign pc_next      = pc_src_e ? pc_target_e : pc_plus4_f;
   assign misaligned_f = |pc_f[1:0];

   // A taken redirect must land even while fetch is stalled.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_f <= RESET_PC;
      end else if (pc_src_e || !stall_f) begin
         pc_f <= pc_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush_d) begin
         instr_d    <= NOP;
         pc_d       <= '0;
         pc_plus4_d <= '0;
         valid_d    <= 1'b0;
      end else if (!stall_d) begin
         instr_d    <= instr_f;
         pc_d       <= pc_f;
         pc_plus4_d <= pc_plus4_f;
         valid_d    <= 1'b1;
      end
   end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-004 stall_f  input  1  hold PC register (fetch stall).
REQ-005 stall_d  input  1  hold IF/ID register contents.
REQ-006 flush_d  input  1  squash IF/ID register (insert bubble).
REQ-007 pc_src_e  input  1  0 = next PC is pc_plus4_f; 1 = redirect to pc_target_e.
REQ-008 pc_target_e  input  32  branch/jump target from execute stage.
REQ-009 instr_f  input  32  instruction word returned by instruction memory for pc_f (combinational read).
REQ-010 pc_f  output  32  current fetch PC, drives instruction memory address.
REQ-011 pc_plus4_f  output  32  pc_f + 4.
REQ-012 misaligned_f  output  1  high when pc_f[1:0] != 2'b00.
REQ-013 instr_d  output  32  registered instruction for decode.
REQ-014 pc_d  output  32  registered PC for decode.
REQ-015 pc_plus4_d  output  32  registered PC+4 for decode.
REQ-016 valid_d  output  1  high when IF/ID holds a real (non-bubble) instruction.

Function
REQ-017 pc_plus4_f SHALL be computed with the team's 32-bit adder module (a = pc_f, b = 32'd4), modulo 2^32, no carry out.
REQ-018 Next-PC mux: pc_next = pc_src_e ? pc_target_e : pc_plus4_f; target used verbatim, low bits not masked.
REQ-019 PC register update priority per edge: reset -> RESET_PC; else pc_src_e=1 -> pc_target_e (redirect overrides stall_f); else stall_f=1 -> hold; else pc_plus4_f.
REQ-020 misaligned_f SHALL be combinational from pc_f; block does not trap, only flags.
REQ-021 IF/ID register update priority per edge: reset -> bubble; else flush_d=1 -> bubble (flush overrides stall_d); else stall_d=1 -> hold all four fields; else load {instr_f, pc_f, pc_plus4_f, valid=1}.
REQ-022 Bubble SHALL be instr_d = 32'h0000_0013 (addi x0,x0,0), pc_d = 0, pc_plus4_d = 0, valid_d = 0.
REQ-023 Latency: instruction at pc_f appears on instr_d one cycle later when not stalled/flushed.
REQ-024 Wrap-around: pc_f = 32'hFFFF_FFFC gives pc_plus4_f = 32'h0000_0000 and PC advances to 0 without error.
REQ-025 Taken redirect (pc_src_e=1) with flush_d=1 in the same cycle: PC loads target, IF/ID becomes bubble; the wrong-path instr_f is discarded.
REQ-026 stall_f=1 with stall_d=0 and flush_d=0 SHALL still load IF/ID (caller responsibility to pair stalls); block does not enforce pairing.
REQ-027 No combinational path from any input to instr_d, pc_d, pc_plus4_d, valid_d.

Reset
REQ-028 While reset=1 at an edge: pc_f = RESET_PC, IF/ID = bubble, regardless of all other inputs.
REQ-029 Reset asserted mid-stall or mid-redirect SHALL override both; first fetch after reset deasserts is RESET_PC.
REQ-030 Outputs before first clock edge are undefined; benches SHALL hold reset for at least one edge.

Verification
REQ-031 Reset then 3 free-running cycles, instr_f = 32'h00A00093 -> pc_f 0,4,8,12; pc_d 0,4,8 one cycle behind; valid_d 0 then 1.
REQ-032 stall_f=stall_d=1 for 2 cycles at pc_f=8 -> pc_f stays 8, pc_d/instr_d held, valid_d unchanged; resumes to 12 after release.
REQ-033 pc_src_e=1, pc_target_e=32'h0000_0100, flush_d=1 at pc_f=12 -> next pc_f=0x100, valid_d=0, instr_d=32'h00000013; following cycle pc_d=0x100.
REQ-034 Redirect with stall_f=1 simultaneously, target 0x200 -> pc_f=0x200 next cycle (redirect wins).
REQ-035 Redirect to 32'hFFFF_FFFC -> pc_plus4_f=0; next pc_f=0; pc_target_e=0x102 -> misaligned_f=1.
REQ-036 reset pulsed while stall_f=stall_d=1 at pc_f=0x40 -> pc_f=RESET_PC, valid_d=0 next cycle.
